// File: rtl/pci_bus_arbiter_if.sv
// Arbitration bundle: per-master requests/grants plus the observed FRAME#/IRDY# pair.
// The master modport is the bus side that drives requests; the slave modport is the arbiter.
interface pci_bus_arbiter_if #(
    parameter int N_MASTERS = 4
);
    localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    logic [N_MASTERS-1:0] NREQ;
    logic                 NFRAME;
    logic                 NIRED;
    logic [N_MASTERS-1:0] NGNT;
    logic [OW-1:0]        owner;
    logic                 bus_idle;

    modport master (
        output NREQ, NFRAME, NIRED,
        input  NGNT, owner, bus_idle
    );

    modport slave (
        input  NREQ, NFRAME, NIRED,
        output NGNT, owner, bus_idle
    );
endinterface

// File: rtl/pci_bus_arbiter.sv
// Round-robin PCI bus arbiter with hidden arbitration, bus parking and an idle-grant timeout.
// FRAME#/IRDY# are only observed; the arbiter never drives the bus itself.
module pci_bus_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int PARK_MASTER = 0,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             reset,
    pci_bus_arbiter_if.slave bus
);
    localparam int OW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [OW-1:0] PARK_IDX = OW'(PARK_MASTER);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, PARK, GRANT, BUSY} state_t;

    state_t               state, state_nx;
    logic [OW-1:0]        owner, owner_nx, rr, rr_nx, winner;
    logic [CW-1:0]        cnt, cnt_nx;
    logic                 bus_idle, any_req, others_req;
    logic [N_MASTERS-1:0] req, others, ngnt, ngnt_nx;
    int unsigned          idx;

    assign req = ~bus.NREQ;

    always_comb begin
        others        = req;
        others[owner] = 1'b0;
        others_req    = |others;
    end

    // Rotating search starting just after the last grantee.
    always_comb begin
        any_req = 1'b0;
        winner  = rr;
        idx     = 0;
        for (int unsigned k = 1; k <= N_MASTERS; k++) begin
            idx = (32'(rr) + k) % N_MASTERS;
            if (!any_req && req[idx[OW-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[OW-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        rr_nx    = rr;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx = GRANT;
                    owner_nx = winner;
                    rr_nx    = winner;
                    cnt_nx   = '0;
                end else begin
                    state_nx = PARK;
                    owner_nx = PARK_IDX;
                end
            end
            PARK: begin
                if (req[PARK_IDX]) begin
                    state_nx = GRANT;
                    owner_nx = PARK_IDX;
                    rr_nx    = PARK_IDX;
                    cnt_nx   = '0;
                end else if (|req) begin
                    state_nx = IDLE;
                end
            end
            GRANT: begin
                if (!bus.NFRAME) begin
                    state_nx = BUSY;
                end else if (!req[owner]) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_MAX && others_req) begin
                    state_nx = IDLE;
                end else if (bus_idle && cnt != CNT_MAX) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            BUSY: begin
                // Grant is withdrawn early; the owner completes its transfer on its own.
                if (others_req || !req[owner]) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ngnt_nx = '1;
        if (state_nx != IDLE) begin
            ngnt_nx[owner_nx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= PARK_IDX;
            rr       <= PARK_IDX;
            cnt      <= '0;
            bus_idle <= 1'b1;
            ngnt     <= '1;
        end else begin
            state    <= state_nx;
            owner    <= owner_nx;
            rr       <= rr_nx;
            cnt      <= cnt_nx;
            bus_idle <= bus.NFRAME & bus.NIRED;
            ngnt     <= ngnt_nx;
        end
    end

    assign bus.NGNT     = ngnt;
    assign bus.owner    = owner;
    assign bus.bus_idle = bus_idle;
endmodule
